// File: rtl/i2s_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : i2s_pkg
// Description : Shared constants and stereo sample type for the I2S
//               transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  localparam int I2S_DATA_W  = 16;
  localparam int I2S_SLOT_W  = 32;
  localparam int I2S_BCK_DIV = 4;

  // One stereo PCM pair, left channel in the upper half.
  typedef struct packed {
    logic [I2S_DATA_W-1:0] left;
    logic [I2S_DATA_W-1:0] right;
  } i2s_stereo_t;

endpackage
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : i2s_clk_gen
// Description : Derives BCK and LRCK from MCK. Provides a BCK falling-edge
//               strobe and a frame-load strobe, both valid in the MCK cycle
//               whose closing edge is the event.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_W  = I2S_SLOT_W,
  parameter int BCK_DIV = I2S_BCK_DIV
) (
  input  logic mck_i,
  input  logic rst_i,
  output logic bck_o,
  output logic lrck_o,
  output logic fall_o,
  output logic load_o
);

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] c_div_half = DIV_W'(BCK_DIV / 2);
  localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] c_slot     = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bck_q, bck_d;
  logic             lrck_q, lrck_d;
  logic             w_fall;

  // Divider and bit counter next state; BCK/LRCK are registered from next state.
  always_comb begin
    w_fall    = (div_cnt_q == c_div_last);
    div_cnt_d = w_fall ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    if (w_fall) begin
      bit_cnt_d = (bit_cnt_q == c_bit_last) ? '0 : bit_cnt_q + 1'b1;
      lrck_d    = (bit_cnt_d >= c_slot);
    end
    bck_d  = (div_cnt_d >= c_div_half);
    fall_o = w_fall;
    load_o = w_fall && (bit_cnt_q == c_bit_last);
  end

  // Counter and clock-output registers.
  always_ff @(posedge mck_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bit_cnt_q <= c_bit_last;
      bck_q     <= 1'b0;
      lrck_q    <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bck_q     <= bck_d;
      lrck_q    <= lrck_d;
    end
  end

  assign bck_o  = bck_q;
  assign lrck_o = lrck_q;

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : i2s_tx
// Description : I2S master transmitter. One-entry stereo holding buffer fed by
//               a valid/ready handshake, 64-bit frame shifter, MSB first with
//               one BCK delay after each LRCK edge. Empty buffer at a frame
//               start sends zeros and pulses underrun_o.
//               Optional macro I2S_TX_UNDERRUN_CNT_EN adds a saturating
//               16-bit underrun counter output underrun_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W  = I2S_DATA_W,
  parameter int SLOT_W  = I2S_SLOT_W,
  parameter int BCK_DIV = I2S_BCK_DIV
) (
  input  logic              mck_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] left_i,
  input  logic [DATA_W-1:0] right_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  output logic              bck_o,
  output logic              lrck_o,
  output logic              data_o,
  output logic              underrun_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt_o
`endif
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PAD_W   = SLOT_W - DATA_W;

  logic               w_fall;
  logic               w_load;
  logic               w_accept;
  logic [SLOT_W-1:0]  w_left_slot;
  logic [SLOT_W-1:0]  w_right_slot;

  logic               buf_full_q, buf_full_d;
  logic [DATA_W-1:0]  buf_left_q, buf_left_d;
  logic [DATA_W-1:0]  buf_right_q, buf_right_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               data_q, data_d;
  logic               underrun_q, underrun_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]        ucnt_q, ucnt_d;
`endif

  i2s_clk_gen #(
    .SLOT_W  (SLOT_W),
    .BCK_DIV (BCK_DIV)
  ) u_clk_gen (
    .mck_i  (mck_i),
    .rst_i  (rst_i),
    .bck_o  (bck_o),
    .lrck_o (lrck_o),
    .fall_o (w_fall),
    .load_o (w_load)
  );

  // Buffer, shifter and serial data next state. The shifter MSB at a falling
  // edge is the bit to drive, so at a load edge the outgoing frame's last bit
  // leaves while the new frame is captured.
  always_comb begin
    buf_full_d   = buf_full_q;
    buf_left_d   = buf_left_q;
    buf_right_d  = buf_right_q;
    shift_d      = shift_q;
    data_d       = data_q;
    underrun_d   = 1'b0;
    w_accept     = sample_valid_i && !buf_full_q;
    w_left_slot  = SLOT_W'(buf_left_q) << PAD_W;
    w_right_slot = SLOT_W'(buf_right_q) << PAD_W;

    if (w_fall) begin
      data_d  = shift_q[FRAME_W-1];
      shift_d = {shift_q[FRAME_W-2:0], 1'b0};
    end

    if (w_load) begin
      if (buf_full_q) begin
        shift_d    = {w_left_slot, w_right_slot};
        buf_full_d = 1'b0;
      end else begin
        shift_d    = '0;
        underrun_d = 1'b1;
      end
    end

    // Only reachable when the buffer was empty before this edge, so it never
    // overwrites a pair that the load above is consuming.
    if (w_accept) begin
      buf_full_d  = 1'b1;
      buf_left_d  = left_i;
      buf_right_d = right_i;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  // Saturating underrun counter, bumped on the edge that raises underrun_o.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Underrun counter register.
  always_ff @(posedge mck_i or posedge rst_i) begin
    if (rst_i) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt_o = ucnt_q;
`endif

  // Datapath registers; reset discards any buffered pair and the frame.
  always_ff @(posedge mck_i or posedge rst_i) begin
    if (rst_i) begin
      buf_full_q  <= 1'b0;
      buf_left_q  <= '0;
      buf_right_q <= '0;
      shift_q     <= '0;
      data_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      buf_full_q  <= buf_full_d;
      buf_left_q  <= buf_left_d;
      buf_right_q <= buf_right_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sample_ready_o = !buf_full_q;
  assign data_o         = data_q;
  assign underrun_o     = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_i2s_tx
// Description : Self-checking bench for i2s_tx. A frame-level model predicts
//               every output from the number of MCK edges since reset;
//               literal checks pin timing and frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int HN = 2048;

  logic        mck = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] left_in = '0;
  logic [15:0] right_in = '0;
  logic        valid = 1'b0;
  logic        ready, bck, lrck, data, ur;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_o;
`endif

  i2s_tx dut (
    .mck_i          (mck),
    .rst_i          (rst),
    .left_i         (left_in),
    .right_i        (right_in),
    .sample_valid_i (valid),
    .sample_ready_o (ready),
    .bck_o          (bck),
    .lrck_o         (lrck),
    .data_o         (data),
    .underrun_o     (ur)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (ucnt_o)
`endif
  );

  always #5 mck = ~mck;

  int vectors = 0;
  int miscompares = 0;

  // Model state: edges since reset release, buffer, current/previous frame.
  int          n;
  bit          m_full;
  i2s_stereo_t m_buf;
  logic [63:0] cur_fr, prev_fr;
  bit          e_ur;
  bit          m_acc;
  int          m_cnt;

  logic d_h [0:HN-1];
  logic u_h [0:HN-1];
  logic r_h [0:HN-1];
  logic b_h [0:HN-1];
  logic l_h [0:HN-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at n=%0d: got %h, expected %h", nm, n, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_frame(input i2s_stereo_t p);
    return {p.left, 16'h0000, p.right, 16'h0000};
  endfunction

  // One MCK edge of the frame-level model.
  task automatic model_edge();
    bit full_before;
    bit load;
    int f;
    full_before = m_full;
    n++;
    f    = n / 4;
    load = (n % 4 == 0) && ((f - 1) % 64 == 0);
    e_ur = 1'b0;
    if (load) begin
      prev_fr = cur_fr;
      if (m_full) begin
        cur_fr = pack_frame(m_buf);
        m_full = 1'b0;
      end else begin
        cur_fr = '0;
        e_ur   = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    m_acc = valid && !full_before;
    if (m_acc) begin
      m_full     = 1'b1;
      m_buf.left  = left_in;
      m_buf.right = right_in;
    end
  endtask

  task automatic check_outputs();
    int   f;
    int   bitc;
    logic e_d, e_l, e_b;
    f   = n / 4;
    e_b = ((n % 4) >= 2);
    if (f == 0) begin
      e_l = 1'b1;
      e_d = 1'b0;
    end else begin
      bitc = (f - 1) % 64;
      e_l  = (bitc >= 32);
      e_d  = (bitc == 0) ? prev_fr[0] : cur_fr[64 - bitc];
    end
    chk("bck", bck, e_b);
    chk("lrck", lrck, e_l);
    chk("data", data, e_d);
    chk("underrun", ur, e_ur);
    chk("ready", ready, !m_full);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("ucnt", ucnt_o, m_cnt[15:0]);
`endif
    if (n < HN) begin
      d_h[n] = data;
      u_h[n] = ur;
      r_h[n] = ready;
      b_h[n] = bck;
      l_h[n] = lrck;
    end
  endtask

  task automatic tick();
    @(posedge mck);
    model_edge();
    @(negedge mck);
    check_outputs();
  endtask

  task automatic run_to(input int last_n);
    while (n < last_n) tick();
  endtask

  // Assert reset away from any clock edge, check reset values before the next
  // edge, then release on a falling MCK edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_bck", bck, 1'b0);
    chk("rst_lrck", lrck, 1'b1);
    chk("rst_data", data, 1'b0);
    chk("rst_underrun", ur, 1'b0);
    chk("rst_ready", ready, 1'b1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("rst_ucnt", ucnt_o, 16'h0000);
`endif
    @(negedge mck);
    @(negedge mck);
    rst     = 1'b0;
    n       = 0;
    m_full  = 1'b0;
    m_buf   = '0;
    cur_fr  = '0;
    prev_fr = '0;
    e_ur    = 1'b0;
    m_acc   = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < HN; i++) begin
      d_h[i] = 1'b0;
      u_h[i] = 1'b0;
      r_h[i] = 1'b0;
      b_h[i] = 1'b0;
      l_h[i] = 1'b0;
    end
  endtask

  // Frame j as seen on data_o: bit k-1 (from MSB) is stable mid-BCK at edge
  // count 256*j + 4*k + 6.
  function automatic logic [63:0] cap(input int j);
    logic [63:0] r;
    r = '0;
    for (int k = 1; k <= 64; k++) r[64 - k] = d_h[256 * j + 4 * k + 6];
    return r;
  endfunction

  initial begin
    int i;
    int guard;
    int bitc;
    n = 0;
    #2;
    apply_reset();

    // Idle: no valid for three frames.
    valid = 1'b0;
    run_to(770);
    chk("idle_bck1", b_h[1], 1'b0);
    chk("idle_bck2", b_h[2], 1'b1);
    chk("idle_bck4", b_h[4], 1'b0);
    chk("idle_bck6", b_h[6], 1'b1);
    chk("idle_lrck3", l_h[3], 1'b1);
    chk("idle_lrck4", l_h[4], 1'b0);
    chk("idle_lrck131", l_h[131], 1'b0);
    chk("idle_lrck132", l_h[132], 1'b1);
    chk("idle_ur3", u_h[3], 1'b0);
    chk("idle_ur4", u_h[4], 1'b1);
    chk("idle_ur5", u_h[5], 1'b0);
    chk("idle_ur260", u_h[260], 1'b1);
    chk("idle_ur516", u_h[516], 1'b1);
    chk("idle_frame1", cap(1), 64'h0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("idle_ucnt3", ucnt_o, 16'd3);
`endif

    // Single pair presented on the first edge after reset.
    @(negedge mck);
    apply_reset();
    left_in  = 16'hA5C3;
    right_in = 16'h5A3C;
    valid    = 1'b1;
    tick();
    valid = 1'b0;
    run_to(600);
    chk("single_ready1", r_h[1], 1'b0);
    chk("single_ur4", u_h[4], 1'b0);
    chk("single_msb", d_h[8], 1'b1);
    chk("single_frame0", cap(0), 64'hA5C3_0000_5A3C_0000);
    chk("single_ur260", u_h[260], 1'b1);

    // Valid arrives exactly on the first load edge with the buffer empty.
    @(negedge mck);
    apply_reset();
    valid = 1'b0;
    run_to(3);
    left_in  = 16'h1234;
    right_in = 16'hABCD;
    valid    = 1'b1;
    tick();
    valid = 1'b0;
    run_to(600);
    chk("edge_ur4", u_h[4], 1'b1);
    chk("edge_ready4", r_h[4], 1'b0);
    chk("edge_frame0", cap(0), 64'h0);
    chk("edge_frame1", cap(1), 64'h1234_0000_ABCD_0000);
    chk("edge_ur260", u_h[260], 1'b0);

    // Back-to-back: valid held high, new pair after each acceptance.
    @(negedge mck);
    apply_reset();
    i        = 1;
    left_in  = 16'h1001;
    right_in = 16'h2001;
    valid    = 1'b1;
    while (n < 1100) begin
      tick();
      if (m_acc) begin
        i++;
        left_in  = 16'h1000 + 16'(i);
        right_in = 16'h2000 + 16'(i);
      end
    end
    valid = 1'b0;
    chk("b2b_ready1", r_h[1], 1'b0);
    chk("b2b_ready4", r_h[4], 1'b1);
    chk("b2b_ready5", r_h[5], 1'b0);
    chk("b2b_ready259", r_h[259], 1'b0);
    chk("b2b_ready260", r_h[260], 1'b1);
    chk("b2b_ur4", u_h[4], 1'b0);
    chk("b2b_ur260", u_h[260], 1'b0);
    chk("b2b_frame0", cap(0), 64'h1001_0000_2001_0000);
    chk("b2b_frame1", cap(1), 64'h1002_0000_2002_0000);
    chk("b2b_frame2", cap(2), 64'h1003_0000_2003_0000);

    // Randomized traffic with a reset in the middle of a right slot.
    @(negedge mck);
    apply_reset();
    for (int c = 0; c < 5000; c++) begin
      if (c == 2000) begin
        // Fill the buffer and reach the right slot, then reset.
        guard = 0;
        bitc  = -1;
        while (!(m_full && bitc >= 40 && bitc <= 50) && guard < 2000) begin
          if (!valid && !m_full) begin
            valid    = 1'b1;
            left_in  = 16'($urandom);
            right_in = 16'($urandom);
          end
          tick();
          if (m_acc) valid = 1'b0;
          bitc = (n >= 4) ? ((n / 4 - 1) % 64) : -1;
          guard++;
        end
        chk("midrst_reached", (guard < 2000), 1'b1);
        valid = 1'b0;
        apply_reset();
        run_to(6);
        chk("midrst_ur4", u_h[4], 1'b1);
        chk("midrst_ready4", r_h[4], 1'b1);
      end
      if (valid && m_acc) valid = 1'b0;
      if (!valid && $urandom_range(0, 399) < 2) begin
        valid    = 1'b1;
        left_in  = 16'($urandom);
        right_in = 16'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter, the sending end of the link that the existing `i2s` receiver consumes.
- Derives BCK and LRCK from MCK and serializes 16-bit stereo PCM, MSB first, with the standard one-BCK delay after each LRCK edge.
- Samples enter through a valid/ready handshake into a one-entry stereo holding buffer.
- Used to drive the DAC path and to loop back into `i2s` for self-test.

Parameters:
- DATA_W, 16: sample width per channel; must satisfy DATA_W <= SLOT_W.
- SLOT_W, 32: BCK periods per channel slot. Frame length is 2*SLOT_W = 64.
- BCK_DIV, 4: MCK cycles per BCK period; even, >= 2.

Ports:
- mck_i  in  1  master clock, the only clock.
- rst_i  in  1  asynchronous, active-high reset.
- left_i  in  DATA_W  left sample, two's complement.
- right_i  in  DATA_W  right sample.
- sample_valid_i  in  1  left_i/right_i are valid.
- sample_ready_o  out  1  holding buffer can accept a pair.
- bck_o  out  1  bit clock.
- lrck_o  out  1  word select: 0 = left, 1 = right.
- data_o  out  1  serial data.
- underrun_o  out  1  one-MCK pulse when a frame starts with the buffer empty.

Behaviour:
- Clocking and reset: one clock (mck_i); reset is asynchronous and active-high. All outputs are registered.
- Reset values:
  - div_cnt=0, bck_o=0, bit_cnt=2*SLOT_W-1, lrck_o=1, data_o=0, underrun_o=0.
  - Buffer is empty, so sample_ready_o=1 after reset.
- Reset mid-frame aborts the frame immediately and discards the buffered pair.
- BCK divider:
  - div_cnt counts 0..BCK_DIV-1 and wraps.
  - bck_o=1 when div_cnt >= BCK_DIV/2.
  - A BCK falling edge is the MCK edge where div_cnt wraps BCK_DIV-1 -> 0.
- Bit counter: bit_cnt (0..2*SLOT_W-1) advances by 1 on every BCK falling edge and wraps.
- lrck_o, updated on the falling edge: 0 for bit_cnt 0..SLOT_W-1, 1 for bit_cnt SLOT_W..2*SLOT_W-1.
- Load event: the falling edge where bit_cnt wraps 2*SLOT_W-1 -> 0. The first falling edge after reset is a load event.
- Frame content at a load event:
  - Buffer full: the frame shifter takes {left, zeros(SLOT_W-DATA_W), right, zeros(SLOT_W-DATA_W)}; the buffer empties.
  - Buffer empty: the frame is all zeros and underrun_o pulses on that same MCK edge.
- data_o, updated on falling edges only, stable across the BCK rising edge:
  - At bit_cnt=k (k >= 1): frame bit index k-1, counted from the MSB.
  - At bit_cnt=0: the last bit of the previous frame.
- Handshake:
  - Transfer occurs when sample_valid_i && sample_ready_o on an MCK edge.
  - sample_ready_o = !buf_full (combinational from buffer state).
  - No bypass into the shifter. Load and handshake on the same edge are legal only when the buffer was already empty before the load.
- Latency: a pair accepted at MCK edge t starts at the next load event; its left MSB appears on data_o one BCK after that edge.
- Widths: no arithmetic on samples; zero padding goes in the LSB side of each slot.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt_o [15:0].
  - Increments on each underrun_o pulse and saturates at 16'hFFFF.
  - Cleared by rst_i.
- Undefined: the port and counter are absent; underrun_o and zero-fill behaviour are unchanged.

Decomposition:
- Shared package i2s_pkg:
  - Constants I2S_DATA_W=16, I2S_SLOT_W=32, I2S_BCK_DIV=4.
  - Typedef of the stereo sample struct {left, right}.
  - The same package is used by `i2s` and its bench.
- Sub-module i2s_clk_gen:
  - Contains div_cnt and bit_cnt.
  - Outputs bck_o, lrck_o, a falling-edge strobe and a load strobe.
- Shifter, holding buffer and handshake live in i2s_tx.

Test Plan:
- Reset release with no valid -> bck_o period 4 MCK, lrck_o period 256 MCK; underrun_o pulses every 256 MCK; data_o stays 0.
- Single pair left=16'hA5C3, right=16'h5A3C:
  - Left MSB (1) appears at bit_cnt=1.
  - Bits 1..16 of the frame read A5C3, bits 33..48 read 5A3C, all others 0.
  - Receiving `i2s` decodes the same values.
- Back-to-back valid held high:
  - First pair is accepted immediately; second waits with ready=0 until the next load event.
  - Consecutive frames carry consecutive pairs with no underrun.
- Valid asserted on the exact load edge with the buffer empty -> the frame is zeros with underrun pulse; the pair is accepted and sent in the following frame.
- rst_i pulsed mid-right-slot -> outputs return to reset values asynchronously; the buffered pair is lost; the next frame starts cleanly.
- With I2S_TX_UNDERRUN_CNT_EN: 3 idle frames -> underrun_cnt_o=3; forced saturation holds at 16'hFFFF.
